// File: rtl/mul_div_unit_pkg.sv
// Shared types for the multiply/divide unit: data width, op and state encodings.
package Parameter;

    localparam int DataWidth = 32;

    typedef logic [DataWidth-1:0] Data;

    typedef struct packed {
        logic valid;
        Data  data;
    } Nullable;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } MduOp;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP
    } MduState;

    function automatic logic is_signed_op(MduOp op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle of the multiply/divide unit.
// DivZero exists only when MDU_DIVZERO_EXC_EN is defined.
interface mul_div_unit_if #(
    parameter int Width = Parameter::DataWidth
);
    logic             Start;
    logic [2:0]       Op;
    logic [Width-1:0] OperandA;
    logic [Width-1:0] OperandB;
    logic             Cancel;
    logic             Busy;
    logic             Done;
    logic [Width-1:0] Hi;
    logic [Width-1:0] Lo;
`ifdef MDU_DIVZERO_EXC_EN
    logic             DivZero;
`endif

    modport master (
        output Start, Op, OperandA, OperandB, Cancel,
`ifdef MDU_DIVZERO_EXC_EN
        input  DivZero,
`endif
        input  Busy, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, Cancel,
`ifdef MDU_DIVZERO_EXC_EN
        output DivZero,
`endif
        output Busy, Done, Hi, Lo
    );

endinterface

// File: rtl/mdu_iter_core.sv
// Unsigned iteration datapath: radix-2 shift-add multiply and
// restoring divide, one bit per step_i. Result is {hi_o, lo_o}.
module mdu_iter_core #(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] hi_o,
    output logic [Width-1:0] lo_o
);
    logic [Width-1:0] acc_q, acc_d;
    logic [Width-1:0] mq_q, mq_d;
    logic [Width-1:0] b_q;
    logic             div_q;
    logic [Width:0]   sum, shl, diff;

    always_comb begin
        sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
        shl  = {acc_q, mq_q[Width-1]};
        diff = shl - {1'b0, b_q};
        if (div_q) begin
            acc_d = diff[Width] ? shl[Width-1:0] : diff[Width-1:0];
            mq_d  = {mq_q[Width-2:0], ~diff[Width]};
        end else begin
            acc_d = sum[Width:1];
            mq_d  = {sum[0], mq_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            mq_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= '0;
            mq_q  <= a_i;
            b_q   <= b_i;
            div_q <= is_div_i;
        end else if (step_i) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
        end
    end

    assign hi_o = acc_q;
    assign lo_o = mq_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: FSM, sign handling and HI/LO state.
// Define MDU_DIVZERO_EXC_EN to trap divide-by-zero via DivZero instead of iterating.
module mul_div_unit
    import Parameter::*;
#(
    parameter int Width    = DataWidth,
    parameter bit SignedEn = 1'b1
) (
    input logic           Clock,
    input logic           Reset,
    mul_div_unit_if.slave mdu
);
    localparam int CntW = $clog2(Width);
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    MduState          state_q;
    MduOp             op;
    logic             busy_q, done_q, div_q, dz_q, neg_q, negr_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] hi_q, lo_q, hi_d, lo_d;
    logic [Width-1:0] a_mag, b_mag, core_hi, core_lo, quo, rem;
    logic [2*Width-1:0] prod, prod_fix;
    logic             sgn, a_neg, b_neg, dz_in;
    logic             is_mul, is_div, accept, iter_load, step;
`ifdef MDU_DIVZERO_EXC_EN
    logic             dzp_q;
`endif

    assign op     = MduOp'(mdu.Op);
    assign sgn    = SignedEn && is_signed_op(op);
    assign a_neg  = sgn & mdu.OperandA[Width-1];
    assign b_neg  = sgn & mdu.OperandB[Width-1];
    assign a_mag  = a_neg ? -mdu.OperandA : mdu.OperandA;
    assign b_mag  = b_neg ? -mdu.OperandB : mdu.OperandB;
    assign dz_in  = mdu.OperandB == '0;
    assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign accept = (state_q == ST_IDLE) && mdu.Start && !mdu.Cancel;
    assign step   = (state_q == ST_MUL) || (state_q == ST_DIV);
`ifdef MDU_DIVZERO_EXC_EN
    assign iter_load = accept && (is_mul || (is_div && !dz_in));
`else
    assign iter_load = accept && (is_mul || is_div);
`endif

    mdu_iter_core #(.Width(Width)) u_core (
        .clk_i   (Clock),
        .rst_ni  (Reset),
        .load_i  (iter_load),
        .step_i  (step),
        .is_div_i(is_div),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .hi_o    (core_hi),
        .lo_o    (core_lo)
    );

    // Divide by zero leaves the dividend as remainder; only Lo needs forcing.
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = neg_q ? -prod : prod;
        quo      = neg_q ? -core_lo : core_lo;
        rem      = negr_q ? -core_hi : core_hi;
        if (div_q) begin
            hi_d = rem;
            lo_d = dz_q ? '1 : quo;
        end else begin
            hi_d = prod_fix[2*Width-1:Width];
            lo_d = prod_fix[Width-1:0];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
`ifdef MDU_DIVZERO_EXC_EN
            dzp_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MDU_DIVZERO_EXC_EN
            dzp_q  <= 1'b0;
`endif
            unique case (state_q)
                ST_IDLE: if (accept) begin
                    unique case (1'b1)
                        op == OP_MTHI: begin
                            hi_q   <= mdu.OperandA;
                            done_q <= 1'b1;
                        end
                        op == OP_MTLO: begin
                            lo_q   <= mdu.OperandA;
                            done_q <= 1'b1;
                        end
                        iter_load: begin
                            state_q <= is_div ? ST_DIV : ST_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            div_q   <= is_div;
                            dz_q    <= dz_in;
                            neg_q   <= a_neg ^ b_neg;
                            negr_q  <= a_neg;
                        end
`ifdef MDU_DIVZERO_EXC_EN
                        is_div && dz_in: begin
                            done_q <= 1'b1;
                            dzp_q  <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                ST_MUL, ST_DIV: begin
                    if (mdu.Cancel) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastCnt) state_q <= ST_FIXUP;
                    end
                end
                ST_FIXUP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!mdu.Cancel) begin
                        hi_q   <= hi_d;
                        lo_q   <= lo_d;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mdu.Busy = busy_q;
    assign mdu.Done = done_q;
    assign mdu.Hi   = hi_q;
    assign mdu.Lo   = lo_q;
`ifdef MDU_DIVZERO_EXC_EN
    assign mdu.DivZero = dzp_q;
`endif

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter Width, default Parameter::DataWidth (32), operand/HI/LO width; legal values are even and at least 8.
REQ-002 SHALL have parameter SignedEn, default 1, which enables the MULT/DIV signed ops; when 0, signed ops execute as unsigned.
REQ-003 SHALL have port Clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port Reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Start  input  1  op request, sampled only in IDLE.
REQ-006 SHALL have port Op  input  3  MduOp: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-007 SHALL have port OperandA  input  Width  multiplicand/dividend/move source.
REQ-008 SHALL have port OperandB  input  Width  multiplier/divisor.
REQ-009 SHALL have port Cancel  input  1  pipeline flush; aborts the in-flight op.
REQ-010 SHALL have port Busy  output  1  high while an iterative op is in flight.
REQ-011 SHALL have port Done  output  1  one-cycle pulse in the cycle after HI/LO update.
REQ-012 SHALL have ports Hi and Lo  output  Width  architectural HI and LO registers.
REQ-013 SHALL have port DivZero  output  1  one-cycle divide-by-zero flag (only with MDU_DIVZERO_EXC_EN).

Function
REQ-014 SHALL implement states IDLE, MUL, DIV, FIXUP, with transitions IDLE->MUL|DIV on accepted Start, MUL|DIV->FIXUP after Width iterations, and FIXUP->IDLE.
REQ-015 SHALL accept Start at edge N only in IDLE with Cancel low; Start in any other state is ignored with no queuing.
REQ-016 SHALL drive Busy high from edge N through edge N+Width+1.
REQ-017 SHALL latch operand magnitudes and result signs at edge N, so that later operand changes have no effect.
REQ-018 SHALL perform multiplication as radix-2 shift-add, one bit per cycle, over edges N+1..N+Width, producing a 2*Width product.
REQ-019 SHALL perform division as radix-2 restoring division, one quotient bit per cycle, over edges N+1..N+Width.
REQ-020 SHALL apply sign correction in FIXUP: the product takes sign A^B, the quotient takes sign A^B, and the remainder takes the sign of the dividend.
REQ-021 SHALL write Hi/Lo atomically at edge N+Width+1 and pulse Done for exactly one cycle after it; latency is Width+1 edges (33 for Width=32).
REQ-022 SHALL produce Hi=upper half and Lo=lower half of the product for multiply, and Hi=remainder, Lo=quotient for divide.
REQ-023 SHALL hold Hi/Lo at their previous values for the entire operation until the update edge.
REQ-024 SHALL write the MIN/-1 signed divide result as Lo=MIN and Hi=0, with no flag raised.
REQ-025 SHALL, without the macro, write divide-by-zero results Lo=all-ones and Hi=OperandA (signed or unsigned), after the full latency.
REQ-026 SHALL, for MTHI/MTLO, write OperandA to Hi/Lo at the accepting edge, keep Busy low, and pulse Done in the next cycle.
REQ-027 SHALL, on Cancel high at any edge while Busy, return to IDLE, leave Hi/Lo unchanged, and suppress Done; Busy is low after that edge.
REQ-028 SHALL, on Cancel and Start both high in IDLE, drop the Start (Cancel wins).
REQ-029 SHALL, on Cancel coinciding with the update edge, suppress the update.

Reset
REQ-030 SHALL, on Reset low at any time including mid-operation, immediately force state=IDLE and Hi=Lo=0; Busy, Done and DivZero go to 0.
REQ-031 SHALL start operation at the first rising edge after Reset deasserts.

Configuration
REQ-032 SHALL, with macro MDU_DIVZERO_EXC_EN defined, expose port DivZero; DIV/DIVU with OperandB=0 skips iteration, leaves Hi/Lo unchanged, and pulses DivZero and Done together in the cycle after the accepting edge.
REQ-033 SHALL, with MDU_DIVZERO_EXC_EN undefined, omit port DivZero and apply REQ-025.

Structure
REQ-034 SHALL place the MduOp enum and the MduState enum in the shared Parameter package alongside Data/Nullable types.
REQ-035 SHALL keep shift-add and restoring iteration datapath in one sub-module, mdu_iter_core; FSM, sign handling and HI/LO live in mul_div_unit.

Verification (Width=32)
REQ-036 SHALL cover MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001, with Done exactly 33 cycles after the Start edge.
REQ-037 SHALL cover MULT -3*7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; and DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-038 SHALL cover DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0; and MTHI 0x1234 -> Hi=0x1234 next edge, Busy never high.
REQ-039 SHALL cover DIVU 5/0 -> without macro Hi=5, Lo=0xFFFFFFFF after 33 cycles; with macro DivZero=Done=1 one cycle after Start, Hi/Lo unchanged.
REQ-040 SHALL cover Cancel at cycle 10 of a DIVU -> Busy low next cycle, no Done, Hi/Lo unchanged; a simultaneous Start is not accepted.
REQ-041 SHALL cover Reset low mid-MULT (cycle 15) -> Hi=Lo=0 and Busy=0 asynchronously, no Done after release.
